dma_chopper_fsm: RTL and testbench

Splits one DMA transfer request into a sequence of block-sized commands for a downstream command FIFO. Given a base address, a total transfer length and a block size, it emits consecutive (address, length) commands, one per cycle when the FIFO has space, and flags the final command. It sits between the transfer-request registers and the DMA command FIFO.

---
 rtl/dma_chopper_fsm.sv | 107 ++++++++++
 tb/tb_dma_chopper_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_chopper_fsm.sv
// Chops one DMA transfer into block-sized (address, length) FIFO commands.
// Ports: clk, reset (sync, active-low), enable, transfer_length[31:0],
//   block_size[23:0], base_address[63:0], fifo_full in;
//   fifo_command_address[63:0], fifo_command_length[23:0],
//   fifo_last_command, fifo_write out.
// Build option CHOPPER_FSM_DONE_EN adds a one-cycle done output.
module dma_chopper_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] transfer_length,
  input  logic [23:0] block_size,
  input  logic [63:0] base_address,
  input  logic        fifo_full,
  output logic [63:0] fifo_command_address,
  output logic [23:0] fifo_command_length,
  output logic        fifo_last_command,
`ifdef CHOPPER_FSM_DONE_EN
  output logic        fifo_write,
  output logic        done
`else
  output logic        fifo_write
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] remaining;
  logic [63:0] offset;

  logic        last;
  logic [23:0] cur_len;
  logic        zero_req;
  logic        issue;

  always_comb begin
    last     = remaining <= {8'd0, block_size};
    // When last, remaining fits in 24 bits.
    cur_len  = last ? remaining[23:0] : block_size;
    zero_req = (transfer_length == 32'd0) ||
               (block_size == 24'd0);
    issue    = state == ISSUE;
  end

  always_comb begin
    fifo_command_address = 64'd0;
    fifo_command_length  = 24'd0;
    fifo_last_command    = 1'b0;
    fifo_write           = 1'b0;
    if (issue) begin
      fifo_command_address = base_address + offset;
      fifo_command_length  = cur_len;
      fifo_last_command    = last;
      fifo_write           = !fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= 32'd0;
      offset    <= 64'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            remaining <= transfer_length;
            offset    <= 64'd0;
            state     <= zero_req ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (!fifo_full) begin
            offset    <= offset + {40'd0, cur_len};
            remaining <= remaining - {8'd0, cur_len};
            if (last) state <= DONE;
          end
        end
        DONE: begin
          // Re-arm only after enable drops.
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHOPPER_FSM_DONE_EN
  logic enter_done;

  always_comb begin
    enter_done = ((state == IDLE) && enable && zero_req) ||
                 (issue && !fifo_full && last);
  end

  always_ff @(posedge clk) begin
    if (!reset) done <= 1'b0;
    else        done <= enter_done;
  end
`endif

endmodule

// File: tb/tb_dma_chopper_fsm.sv
// Directed self-checking bench for dma_chopper_fsm.
// Checks command sequences, stalls, zero cases and mid-transfer reset.
module tb_dma_chopper_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] transfer_length;
  logic [23:0] block_size;
  logic [63:0] base_address;
  logic        fifo_full;
  logic [63:0] fifo_command_address;
  logic [23:0] fifo_command_length;
  logic        fifo_last_command;
  logic        fifo_write;
`ifdef CHOPPER_FSM_DONE_EN
  logic        done;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dma_chopper_fsm dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .transfer_length      (transfer_length),
    .block_size           (block_size),
    .base_address         (base_address),
    .fifo_full            (fifo_full),
    .fifo_command_address (fifo_command_address),
    .fifo_command_length  (fifo_command_length),
    .fifo_last_command    (fifo_last_command),
`ifdef CHOPPER_FSM_DONE_EN
    .fifo_write           (fifo_write),
    .done                 (done)
`else
    .fifo_write           (fifo_write)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cmd(input string tag,
                           input logic w,
                           input logic [63:0] a,
                           input logic [23:0] l,
                           input logic lst);
    check({tag, ".wr"},   {63'd0, fifo_write}, {63'd0, w});
    check({tag, ".addr"}, fifo_command_address, a);
    check({tag, ".len"},  {40'd0, fifo_command_length},
          {40'd0, l});
    check({tag, ".last"}, {63'd0, fifo_last_command},
          {63'd0, lst});
  endtask

  task automatic check_done(input string tag, input logic exp);
`ifdef CHOPPER_FSM_DONE_EN
    check({tag, ".done"}, {63'd0, done}, {63'd0, exp});
`endif
  endtask

  task automatic setup(input logic [63:0] b,
                       input logic [31:0] tl,
                       input logic [23:0] bs);
    base_address    = b;
    transfer_length = tl;
    block_size      = bs;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    fifo_full = 1'b0;
    setup(64'd0, 32'd0, 24'd0);
    repeat (3) cyc();
    check_cmd("rst", 0, 64'd0, 24'd0, 0);
    check_done("rst", 0);
    reset = 1'b1;
    cyc();
    check_cmd("idle", 0, 64'd0, 24'd0, 0);

    // 4095 bytes in 1024-byte blocks; enable drop ignored.
    setup(64'd0, 32'd4095, 24'd1024);
    enable = 1'b1;
    cyc();
    check_cmd("t1c0", 1, 64'd0, 24'd1024, 0);
    enable = 1'b0;
    cyc();
    check_cmd("t1c1", 1, 64'd1024, 24'd1024, 0);
    cyc();
    check_cmd("t1c2", 1, 64'd2048, 24'd1024, 0);
    check_done("t1c2", 0);
    cyc();
    check_cmd("t1c3", 1, 64'd3072, 24'd1023, 1);
    cyc();
    check_cmd("t1done", 0, 64'd0, 24'd0, 0);
    check_done("t1done", 1);
    cyc();
    check_cmd("t1idle", 0, 64'd0, 24'd0, 0);
    check_done("t1idle", 0);

    // Exact multiple: no trailing zero-length command.
    setup(64'h1000, 32'd2048, 24'd1024);
    enable = 1'b1;
    cyc();
    check_cmd("t2c0", 1, 64'h1000, 24'd1024, 0);
    enable = 1'b0;
    cyc();
    check_cmd("t2c1", 1, 64'h1400, 24'd1024, 1);
    cyc();
    check_cmd("t2done", 0, 64'd0, 24'd0, 0);
    cyc();

    // Stall three cycles after the second write.
    setup(64'd0, 32'd4095, 24'd1024);
    enable = 1'b1;
    cyc();
    check_cmd("t3c0", 1, 64'd0, 24'd1024, 0);
    enable = 1'b0;
    cyc();
    check_cmd("t3c1", 1, 64'd1024, 24'd1024, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      fifo_full = 1'b1;
      #1;
      check_cmd("t3stall", 0, 64'd2048, 24'd1024, 0);
    end
    fifo_full = 1'b0;
    #1;
    check_cmd("t3c2", 1, 64'd2048, 24'd1024, 0);
    cyc();
    check_cmd("t3c3", 1, 64'd3072, 24'd1023, 1);
    cyc();
    check_cmd("t3done", 0, 64'd0, 24'd0, 0);
    cyc();

    // Zero length, enable held: no writes, no restart.
    setup(64'h40, 32'd0, 24'd1024);
    enable = 1'b1;
    cyc();
    check_cmd("t4z", 0, 64'd0, 24'd0, 0);
    check_done("t4z", 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_cmd("t4hold", 0, 64'd0, 24'd0, 0);
      check_done("t4hold", 0);
    end
    setup(64'h2000, 32'd100, 24'd1024);
    cyc();
    check_cmd("t4norst", 0, 64'd0, 24'd0, 0);
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();
    check_cmd("t5single", 1, 64'h2000, 24'd100, 1);
    enable = 1'b0;
    cyc();
    check_cmd("t5done", 0, 64'd0, 24'd0, 0);
    check_done("t5done", 1);
    cyc();

    // Zero block size.
    setup(64'h80, 32'd50, 24'd0);
    enable = 1'b1;
    cyc();
    check_cmd("t4b0", 0, 64'd0, 24'd0, 0);
    check_done("t4b0", 1);
    enable = 1'b0;
    cyc();
    cyc();

    // Reset after the first write, then restart from 0.
    setup(64'd0, 32'd4095, 24'd1024);
    enable = 1'b1;
    cyc();
    check_cmd("t6c0", 1, 64'd0, 24'd1024, 0);
    reset = 1'b0;
    cyc();
    check_cmd("t6rst", 0, 64'd0, 24'd0, 0);
    reset = 1'b1;
    cyc();
    check_cmd("t6r0", 1, 64'd0, 24'd1024, 0);
    enable = 1'b0;
    cyc();
    check_cmd("t6r1", 1, 64'd1024, 24'd1024, 0);
    cyc();
    check_cmd("t6r2", 1, 64'd2048, 24'd1024, 0);
    cyc();
    check_cmd("t6r3", 1, 64'd3072, 24'd1023, 1);
    cyc();
    check_cmd("t6done", 0, 64'd0, 24'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
